fifo_rd_stream: RTL
===================

# fifo_rd_stream

Read-side controller for the 4096-deep FIFO. It drains the FIFO's registered read port (`rd`/`empty`/`data_out`, one-cycle read latency) and presents the words as a valid/ready stream to the downstream consumer. A 2-entry output buffer gives full throughput and absorbs back-pressure without losing words. A wrapping delivered-word counter lets the bench and system logic confirm drain progress.

## Interface
- `DataWidth`, 16, FIFO word width
- `Depth`, 4096, depth of the attached FIFO; sets the counter width only
- `CntWidth`, $clog2(Depth)+1 (=13), width of `out_count`
- `clk`  input  1  rising-edge clock
- `rst`  input  1  synchronous, active-high reset
- `en`  input  1  drain enable; when low, no new FIFO reads are issued
- `fifo_empty`  input  1  FIFO empty flag
- `fifo_rd`  output  1  FIFO read strobe
- `fifo_data`  input  DataWidth  FIFO `data_out`; valid the cycle after `fifo_rd` was high
- `m_data`  output  DataWidth  stream data
- `m_valid`  output  1  stream valid
- `m_ready`  input  1  stream ready from the consumer
- `out_count`  output  CntWidth  count of words accepted downstream (`m_valid && m_ready`); wraps
- `busy`  output  1  high when the buffer holds a word or a read is in flight

## Operation
- **State**
  - 2-entry buffer, `buf[0]` is the head.
  - `occ` is the occupancy, 0..2.
  - `inflight` (1 bit) is set in the cycle after `fifo_rd`.
- **Pop:** `pop = m_valid && m_ready`.
- **Read issue** (combinational): `fifo_rd = !rst && en && !fifo_empty && (occ + inflight - pop) < 2`.
- **Capture:** when `inflight` is 1, `fifo_data` is written into the buffer at the clock edge.
  - The word goes to slot `occ - pop`.
  - If a pop happens in the same cycle, `buf[1]` shifts to `buf[0]` first.
- **Stream outputs:**
  - `m_valid = (occ != 0)`.
  - `m_data = buf[0]`.
  - `m_data` is held stable while `m_valid && !m_ready`.
- **Count:** `out_count` increments by 1 on each pop and wraps from 2^CntWidth-1 to 0.
- **Busy:** `busy = (occ != 0) || inflight`.
- **Invariant:** `occ + inflight <= 2` always. The buffer never overflows and no FIFO word is dropped or duplicated.
- **`en` deasserted mid-drain:**
  - No new reads are issued.
  - The in-flight word is still captured.
  - Buffered words are still delivered.
- **`fifo_empty` high:** no reads are issued. `m_valid` remains high while `occ > 0`.
- **Simultaneous capture and pop:** handled in the same cycle. `occ` is unchanged.
- **Reset, including mid-operation:**
  - All of `occ`, `inflight`, `m_valid`, `m_data` (0), `out_count` (0), `busy` go to 0.
  - `fifo_rd` is 0 while `rst` is high.
  - A word returned by the FIFO in the cycle after reset is ignored, because `inflight` is cleared.

## Timing
- **Read-to-valid latency:** `fifo_rd` high in cycle N → `fifo_data` captured at the end of N+1 → `m_valid` high in N+2.
- **Throughput:** with `m_ready` held high and the FIFO non-empty, `fifo_rd` stays high every cycle and one word is delivered per cycle after the initial 2-cycle latency.
- **Back-pressure:**
  - When `m_ready` falls, `fifo_rd` drops in the same cycle.
  - `occ` reaches 2 in at most 1 cycle.
  - When `m_ready` rises, reads resume in that same cycle, because `pop` is counted in the issue condition.
- **Combinational paths:** `fifo_rd` depends combinationally on `m_ready`, `en` and `fifo_empty`. All other outputs are registered.

## Test plan
- **Full-speed drain:**
  - Stimulus: write 0..4095 into the FIFO, then `en=1`, `m_ready=1`.
  - Required: `m_data` sequence 0..4095 with no gaps or repeats.
  - Required: first `m_valid` 2 cycles after the first `fifo_rd`.
  - Required: `out_count` = 4096, `busy` = 0 at end.
- **Back-pressure:**
  - Stimulus: as above, with `m_ready` toggled 1/0 on a pseudo-random pattern.
  - Required: ordered 0..4095 delivered and `occ` never exceeds 2.
  - Required: `m_data` stable whenever `m_valid && !m_ready`.
- **Consumer stall:**
  - Stimulus: `m_ready=0` for 100 cycles with the FIFO holding 10 words.
  - Required: exactly 2 `fifo_rd` pulses, then none; FIFO retains 8 words.
  - Required: on `m_ready=1`, words are delivered at 1/cycle.
- **Enable gating:**
  - Stimulus: drop `en` mid-drain after word 500 is read.
  - Required: at most 2 further words delivered, then `m_valid=0`, `busy=0`.
  - Stimulus: re-raise `en`.
  - Required: delivery resumes at the next value with no loss.
- **Empty FIFO:**
  - Stimulus: `en=1`, FIFO empty for 50 cycles.
  - Required: `fifo_rd=0` and `m_valid=0` throughout.
  - Stimulus: a single write of 0x1234.
  - Required: exactly one `fifo_rd`; `m_data=0x1234` delivered once.
- **Reset mid-operation:**
  - Stimulus: assert `rst` while `occ=2` and `inflight=1`.
  - Required: next cycle all outputs are 0 and `out_count=0`.
  - Required: the FIFO word returned after reset is not presented on `m_data`.

Source files
------------

// File: rtl/fifo_rd_stream.sv
// fifo_rd_stream: drains a registered-read FIFO into a 2-entry buffered valid/ready stream
module fifo_rd_stream #(
  parameter int DataWidth = 16,
  parameter int Depth = 4096,
  parameter int CntWidth = $clog2(Depth) + 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic                 fifo_empty,
  output logic                 fifo_rd,
  input  logic [DataWidth-1:0] fifo_data,
  output logic [DataWidth-1:0] m_data,
  output logic                 m_valid,
  input  logic                 m_ready,
  output logic [CntWidth-1:0]  out_count,
  output logic                 busy
);
  logic [1:0] occ;
  logic [1:0] wr_idx;
  logic [2:0] level;
  logic inflight;
  logic pop;
  logic [DataWidth-1:0] slot1;
  assign pop = m_valid && m_ready;
  assign level = {1'b0, occ} + {2'b0, inflight} - {2'b0, pop};
  assign wr_idx = occ - {1'b0, pop};
  assign fifo_rd = !rst && en && !fifo_empty && level < 3'd2;
  // Buffer shift/capture, occupancy and registered stream/status outputs; level is next occupancy
  always_ff @(posedge clk) begin
    if (rst) begin
      occ <= '0;
      inflight <= 1'b0;
      m_valid <= 1'b0;
      busy <= 1'b0;
      m_data <= '0;
      slot1 <= '0;
      out_count <= '0;
    end else begin
      occ <= level[1:0];
      inflight <= fifo_rd;
      m_valid <= level != 3'd0;
      busy <= level != 3'd0 || fifo_rd;
      m_data <= (inflight && wr_idx == 2'd0) ? fifo_data : pop ? slot1 : m_data;
      slot1 <= (inflight && wr_idx == 2'd1) ? fifo_data : slot1;
      out_count <= out_count + CntWidth'(pop);
    end
  end
endmodule
